// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port cache-to-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Ownership state of the single external memory port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Port identifiers as stored in the round-robin 'last' register
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/outstanding_ctr.sv
// Outstanding-read counter: reads accepted by memory but not yet returned.
// Latency: registered count; full/zero/zero_nxt/underflow are combinational.
// Backpressure: full drops in a cycle that retires a read, so a slot freed by a return is reusable in that same cycle.
module outstanding_ctr #(
  parameter int  MAX_OUT = 4,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic zero_nxt,
  output logic underflow
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          at_max;
  logic          do_inc;
  logic          do_dec;

  // A return with nothing outstanding is a protocol error and is not counted
  assign zero      = (cnt == '0);
  assign at_max    = (cnt == CW'(MAX_OUT));
  assign do_dec    = dec & ~zero;
  assign underflow = dec & zero;
  assign full      = at_max & ~do_dec;
  assign do_inc    = inc & ~full;

  // Net update: simultaneous accept and return leaves the count unchanged
  always_comb begin
    cnt_nxt = cnt;
    if (do_inc && !do_dec) begin
      cnt_nxt = cnt + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  assign zero_nxt = (cnt_nxt == '0);

  // Count register; reset drops any in-flight reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (icache = port 0, dcache = port 1) onto one word-granular memory port.
// Latency: one cycle from request in IDLE to grant; request and read-return paths are combinational once owned.
// Backpressure: owner sees memory ready, withheld while MAX_OUT reads are outstanding; non-owner sees ready = 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_p0_addr,
  input  logic          i_p0_ren,
  input  logic          i_p0_wen,
  input  logic [DW-1:0] i_p0_wdata,
  output logic          o_p0_ready,
  output logic [DW-1:0] o_p0_rdata,
  output logic          o_p0_valid,
  input  logic [AW-1:0] i_p1_addr,
  input  logic          i_p1_ren,
  input  logic          i_p1_wen,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p1_ready,
  output logic [DW-1:0] o_p1_rdata,
  output logic          o_p1_valid,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_ren,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ready,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_valid,
  output logic          o_err
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       last_nxt;
  logic       req0;
  logic       req1;
  logic       full;
  logic       zero;
  logic       zero_nxt;
  logic       underflow;
  logic       rd_accept;
  logic       own_both;

  assign req0      = i_p0_ren | i_p0_wen;
  assign req1      = i_p1_ren | i_p1_wen;
  assign rd_accept = o_mem_ren & i_mem_ready;
  assign own_both  = ((state == OWN0) & i_p0_ren & i_p0_wen) |
                     ((state == OWN1) & i_p1_ren & i_p1_wen);

  outstanding_ctr #(
    .MAX_OUT (MAX_OUT)
  ) u_ctr (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .inc       (rd_accept),
    .dec       (i_mem_valid),
    .full      (full),
    .zero      (zero),
    .zero_nxt  (zero_nxt),
    .underflow (underflow)
  );

  // Steer the owner's request to memory and route read returns back to the owner only
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_p0_ready  = 1'b0;
    o_p1_ready  = 1'b0;
    o_p0_valid  = 1'b0;
    o_p1_valid  = 1'b0;
    o_p0_rdata  = '0;
    o_p1_rdata  = '0;
    case (state)
      OWN0: begin
        o_mem_addr  = i_p0_addr;
        o_mem_wdata = i_p0_wdata;
        o_mem_ren   = i_p0_ren & ~full;
        o_mem_wen   = i_p0_wen;
        o_p0_ready  = i_mem_ready & ~(i_p0_ren & full);
        o_p0_valid  = i_mem_valid & ~zero;
        o_p0_rdata  = i_mem_rdata;
      end
      OWN1: begin
        o_mem_addr  = i_p1_addr;
        o_mem_wdata = i_p1_wdata;
        o_mem_ren   = i_p1_ren & ~full;
        o_mem_wen   = i_p1_wen;
        o_p1_ready  = i_mem_ready & ~(i_p1_ren & full);
        o_p1_valid  = i_mem_valid & ~zero;
        o_p1_rdata  = i_mem_rdata;
      end
      default: ;
    endcase
  end

  // Grant selection: round-robin on ties, hold until the owner is idle with no reads in flight
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last == PORT1)) begin
          state_nxt = OWN0;
          last_nxt  = PORT0;
        end else if (req1) begin
          state_nxt = OWN1;
          last_nxt  = PORT1;
        end
      end
      OWN0: begin
        if (!i_p0_ren && !i_p0_wen && zero_nxt) begin
          if (req1) begin
            state_nxt = OWN1;
            last_nxt  = PORT1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OWN1: begin
        if (!i_p1_ren && !i_p1_wen && zero_nxt) begin
          if (req0) begin
            state_nxt = OWN0;
            last_nxt  = PORT0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and sticky protocol-error flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      last  <= PORT1;
      o_err <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      o_err <= o_err | underflow | own_both;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter between the instruction cache (port 0) and the data cache (port 1) and the single external word-granular memory port. Each cache connects its memory-side interface (ready/addr/ren/wen/wdata/rdata/valid) to one arbiter port unchanged. The arbiter grants one cache at a time and holds the grant until that cache's line fill or write-through has fully drained, so read data returns to the cache that issued the request. Between ownerships, priority alternates round-robin.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_OUT, 4, maximum accepted-but-unreturned reads; counter width is clog2(MAX_OUT+1)
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_pN_addr / i_pN_ren / i_pN_wen / i_pN_wdata  in  AW/1/1/DW  request from cache N (N = 0, 1)
- o_pN_ready  out  1  request from cache N is accepted this cycle
- o_pN_rdata / o_pN_valid  out  DW/1  read return routed to cache N
- o_mem_addr / o_mem_ren / o_mem_wen / o_mem_wdata  out  AW/1/1/DW  to memory
- i_mem_ready / i_mem_rdata / i_mem_valid  in  1/DW/1  from memory
- o_err  out  1  sticky protocol-error flag

## Operation
- States: IDLE, OWN0, OWN1. Register `last` holds the most recently granted port; reset value 1, so port 0 wins the first tie.
- IDLE:
  - No grant; all o_pN_ready = 0; memory ren/wen = 0.
  - reqN = ren|wen on port N.
  - Only one port requesting: go to OWN of that port.
  - Both requesting: go to OWN of the port that is not `last`.
  - Entering OWNx sets last = x.
- OWNx, memory drive:
  - o_mem_addr and o_mem_wdata = port x values.
  - o_mem_ren = i_px_ren & ~full, where full means cnt == MAX_OUT.
  - o_mem_wen = i_px_wen.
- OWNx, port x handshake:
  - o_px_ready = i_mem_ready & ~(i_px_ren & full).
  - The other port sees ready = 0 and valid = 0.
- Read routing: o_px_valid = i_mem_valid and o_px_rdata = i_mem_rdata, combinational, for port x only. The non-owner's rdata is 0.
- Outstanding counter `cnt`:
  - +1 on an accepted read (o_mem_ren & i_mem_ready).
  - −1 on i_mem_valid.
  - Both in the same cycle: unchanged.
  - Writes are never counted.
- Release from OWNx occurs when i_px_ren = 0, i_px_wen = 0, and cnt == 0 (after this cycle's update):
  - If the other port is requesting, go directly to OWN(other) next cycle.
  - Otherwise go to IDLE.
- Protocol errors set o_err, which stays set until reset:
  - i_mem_valid with cnt == 0: cnt stays 0 and the data is not routed.
  - Ren and wen asserted together on the owner port.
- Reset mid-transfer: state → IDLE, cnt → 0, in-flight reads are dropped. Late valids then count as protocol errors.

## Timing
- Reset values:
  - All o_mem_*, o_pN_ready, o_pN_valid, o_pN_rdata = 0.
  - o_err = 0, state = IDLE, cnt = 0.
- Grant latency: a request seen in IDLE at edge k gets ready at earliest in cycle k+1. A handover OWNx→OWNy costs no idle cycle.
- Memory request path and read return path are combinational; there is no added read latency.
- Caches hold addr/wdata stable while ready = 0, so the arbiter does not register request fields.

## Structure
- Package `mem_arb_pkg`: state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and port ID constants.
- Sub-module `outstanding_ctr`: saturating up/down counter of width clog2(MAX_OUT+1), with ports inc, dec, full, zero, underflow.
  - underflow feeds o_err.
- Everything else lives in one top module.

## Test plan
- Single fill: port 0 read burst at 0x100, memory returns 0xA0..0xA3 with 2-cycle latency.
  - Port 0 receives 4 valids in order.
  - Port 1 valid never asserts.
  - cnt returns to 0 and state returns to IDLE.
- Contention: both ports request in the same IDLE cycle after reset.
  - Port 0 granted first.
  - After its drain, port 1 is granted directly with no IDLE cycle.
  - On the next tie, port 0 is granted (last = 1).
- Backpressure: MAX_OUT=2, memory withholds valid.
  - After 2 accepted reads, o_mem_ren = 0 and o_p0_ready = 0.
  - The first valid re-enables ren the same cycle.
- Write-through: port 1 writes 0xDEADBEEF to 0x204 while memory ready is low for 3 cycles.
  - o_mem_wen is held with constant addr/data.
  - Release occurs the cycle after ready and wen drop.
- Errors and reset:
  - i_mem_valid with cnt = 0 → o_err = 1 and stays set.
  - Asserting i_rst_n low mid-burst → all outputs 0 immediately (asynchronously), o_err = 0, state = IDLE.
